// File: rtl/dl_cycle_tracer.sv
// dl_cycle_tracer
//   Watches a per-process blocked/token vector, confirms a deadlock once the
//   blocked set stays stable (or grows) for FILTER_CYCLES cycles, then walks
//   each wait-for cycle one at a time. For every component seen on a cycle it
//   emits a trace record into a first-word-fall-through FIFO. The FSM never
//   stalls on trace backpressure: records that cannot be stored are dropped
//   and a sticky overflow flag is raised.
//
// Ports
//   dl_clock        clock
//   dl_reset        asynchronous active-low reset
//   dl_in_vec       per-process blocked/token vector
//   dl_detect_out   deadlock confirmed (sticky until reset)
//   origin          one-hot start process of the cycle being traced (DETECTED only)
//   token_clear     one-cycle pulse when the traced cycle closes
//   trace_valid/trace_ready/trace_last/trace_cycle_id/trace_comp_id/
//   trace_proc_idx  trace record stream
//   report_done     all cycles reported (sticky)
//   cycle_count     number of cycles reported (saturating)
//   trace_overflow  sticky record-dropped flag
module dl_cycle_tracer #(
  parameter int PROC_NUM      = 4,
  parameter int FILTER_CYCLES = 1000,
  parameter int TRACE_DEPTH   = 8,
  parameter int ID_W          = 8,
  localparam int IDX_W        = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1
) (
  input  logic                dl_clock,
  input  logic                dl_reset,
  input  logic [PROC_NUM-1:0] dl_in_vec,
  output logic                dl_detect_out,
  output logic [PROC_NUM-1:0] origin,
  output logic                token_clear,
  output logic                trace_valid,
  input  logic                trace_ready,
  output logic                trace_last,
  output logic [ID_W-1:0]     trace_cycle_id,
  output logic [ID_W-1:0]     trace_comp_id,
  output logic [IDX_W-1:0]    trace_proc_idx,
  output logic                report_done,
  output logic [ID_W-1:0]     cycle_count,
  output logic                trace_overflow
);

  localparam int KC_W  = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [KC_W-1:0] KC_LAST = KC_W'(FILTER_CYCLES - 1);
  localparam int PTR_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int REC_W = 2 * ID_W + IDX_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_FILTER, S_DETECTED, S_REPORT, S_DONE} state_t;

  state_t                state, state_nxt;
  logic [PROC_NUM-1:0]   detect_reg, done_reg, origin_reg, origin_cur;
  logic [KC_W-1:0]       keep_cnt;
  logic [ID_W-1:0]       cycle_id, comp_id, cycle_cnt;
  logic                  push, push_ok, pop, fifo_full;
  logic [REC_W-1:0]      push_rec, head_rec;
  logic [REC_W-1:0]      fifo_mem [TRACE_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        fifo_cnt;

  function automatic logic [PROC_NUM-1:0] lowest_one(input logic [PROC_NUM-1:0] v);
    return v & (~v + PROC_NUM'(1));
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
    lowest_idx = '0;
    for (int i = PROC_NUM - 1; i >= 0; i--)
      if (v[i]) lowest_idx = IDX_W'(i);
  endfunction

  function automatic logic [ID_W-1:0] sat_inc(input logic [ID_W-1:0] v);
    return (&v) ? v : v + ID_W'(1);
  endfunction

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) state <= S_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    origin_cur  = '0;
    token_clear = 1'b0;
    push        = 1'b0;
    push_rec    = '0;
    case (state)
      S_IDLE:
        if (|dl_in_vec) state_nxt = S_FILTER;
      S_FILTER:
        // Any previously blocked process that released breaks the filter.
        if ((detect_reg & ~dl_in_vec) != '0) state_nxt = S_IDLE;
        else if (keep_cnt == KC_LAST)        state_nxt = S_DETECTED;
      S_DETECTED:
        if (detect_reg != done_reg) begin
          origin_cur = lowest_one(detect_reg & ~done_reg);
          push       = 1'b1;
          push_rec   = {cycle_id, ID_W'(1), lowest_idx(origin_cur), 1'b0};
          state_nxt  = S_REPORT;
        end else begin
          state_nxt  = S_DONE;
        end
      S_REPORT:
        // The token returning to the origin closes the cycle.
        if (|(dl_in_vec & origin_reg)) begin
          token_clear = 1'b1;
          push        = 1'b1;
          push_rec    = {cycle_id, comp_id, lowest_idx(origin_reg), 1'b1};
          state_nxt   = S_DETECTED;
        end else if (|dl_in_vec) begin
          push        = 1'b1;
          push_rec    = {cycle_id, comp_id, lowest_idx(dl_in_vec), 1'b0};
        end
      S_DONE: ;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      detect_reg <= '0;
      done_reg   <= '0;
      origin_reg <= '0;
      keep_cnt   <= '0;
      cycle_id   <= ID_W'(1);
      comp_id    <= ID_W'(1);
      cycle_cnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          detect_reg <= dl_in_vec;
          keep_cnt   <= '0;
        end
        S_FILTER:
          if ((detect_reg & ~dl_in_vec) != '0) keep_cnt <= '0;
          else if (keep_cnt != KC_LAST)        keep_cnt <= keep_cnt + KC_W'(1);
        S_DETECTED:
          if (detect_reg != done_reg) begin
            origin_reg <= origin_cur;
            comp_id    <= ID_W'(2);
          end
        S_REPORT: begin
          if (|(dl_in_vec & origin_reg)) begin
            cycle_id  <= sat_inc(cycle_id);
            cycle_cnt <= sat_inc(cycle_cnt);
          end else if (|dl_in_vec) begin
            comp_id   <= sat_inc(comp_id);
          end
          // Processes seen on a deadlocked path are not used as future origins.
          if (|(dl_in_vec & detect_reg)) done_reg <= done_reg | dl_in_vec;
        end
        default: ;
      endcase
    end
  end

  // ---- trace FIFO (first-word-fall-through) ----
  assign fifo_full = (fifo_cnt == (PTR_W + 1)'(TRACE_DEPTH));
  assign pop       = trace_valid && trace_ready;
  assign push_ok   = push && (!fifo_full || pop);

  always_ff @(posedge dl_clock or negedge dl_reset) begin
    if (!dl_reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fifo_cnt       <= '0;
      trace_overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
        default: ;
      endcase
      if (push && !push_ok) trace_overflow <= 1'b1;
    end
  end

  always_ff @(posedge dl_clock) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_rec;
  end

  // Record fields are forced to zero while the stream is idle (and in reset).
  assign trace_valid = (fifo_cnt != '0);
  assign head_rec    = trace_valid ? fifo_mem[rd_ptr] : '0;
  assign {trace_cycle_id, trace_comp_id, trace_proc_idx, trace_last} = head_rec;

  assign dl_detect_out = (|detect_reg) &&
                         (state == S_DETECTED || state == S_REPORT || state == S_DONE);
  assign origin        = origin_cur;
  assign report_done   = (state == S_DONE);
  assign cycle_count   = cycle_cnt;

endmodule

// File: tb/tb_dl_cycle_tracer.sv
module tb_dl_cycle_tracer;

  logic       dl_clock = 1'b0;
  logic       dl_reset;
  logic [2:0] dl_in_vec;
  logic       ready_m, ready_b;

  logic       m_det, m_tc, m_tv, m_last, m_rdone, m_ovf;
  logic [2:0] m_org;
  logic [7:0] m_cid, m_comp, m_cc;
  logic [1:0] m_idx;
  logic       b_det, b_tc, b_tv, b_last, b_rdone, b_ovf;
  logic [2:0] b_org;
  logic [7:0] b_cid, b_comp, b_cc;
  logic [1:0] b_idx;

  int total = 0;
  int bad   = 0;
  logic [18:0] q_m[$];
  logic [18:0] q_b[$];

  always #5 dl_clock = ~dl_clock;

  dl_cycle_tracer #(.PROC_NUM(3), .FILTER_CYCLES(4), .TRACE_DEPTH(4), .ID_W(8)) u_dut (
    .dl_clock(dl_clock), .dl_reset(dl_reset), .dl_in_vec(dl_in_vec),
    .dl_detect_out(m_det), .origin(m_org), .token_clear(m_tc),
    .trace_valid(m_tv), .trace_ready(ready_m), .trace_last(m_last),
    .trace_cycle_id(m_cid), .trace_comp_id(m_comp), .trace_proc_idx(m_idx),
    .report_done(m_rdone), .cycle_count(m_cc), .trace_overflow(m_ovf)
  );

  dl_cycle_tracer #(.PROC_NUM(3), .FILTER_CYCLES(4), .TRACE_DEPTH(2), .ID_W(8)) u_bp (
    .dl_clock(dl_clock), .dl_reset(dl_reset), .dl_in_vec(dl_in_vec),
    .dl_detect_out(b_det), .origin(b_org), .token_clear(b_tc),
    .trace_valid(b_tv), .trace_ready(ready_b), .trace_last(b_last),
    .trace_cycle_id(b_cid), .trace_comp_id(b_comp), .trace_proc_idx(b_idx),
    .report_done(b_rdone), .cycle_count(b_cc), .trace_overflow(b_ovf)
  );

  // Record every accepted trace beat, sampled mid-cycle.
  always @(negedge dl_clock) begin
    if (m_tv && ready_m) q_m.push_back({m_cid, m_comp, m_idx, m_last});
    if (b_tv && ready_b) q_b.push_back({b_cid, b_comp, b_idx, b_last});
  end

  typedef struct {
    logic [2:0] in;
    logic       det;
    logic [2:0] org;
    logic       tc;
    logic       tv;
    logic [7:0] cid;
    logic [7:0] comp;
    logic [1:0] idx;
    logic       last;
    logic       rdone;
    logic [7:0] cc;
  } vec_t;

  vec_t tbl[11];

  function automatic logic [63:0] obs_m();
    return 64'({m_det, m_org, m_tc, m_tv, m_cid, m_comp, m_idx, m_last, m_rdone, m_cc});
  endfunction

  function automatic logic [63:0] pack_exp(input vec_t v);
    return 64'({v.det, v.org, v.tc, v.tv, v.cid, v.comp, v.idx, v.last, v.rdone, v.cc});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge dl_clock);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input int n);
    dl_in_vec = v;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    dl_reset  = 1'b0;
    dl_in_vec = 3'b000;
    tick();
    tick();
    chk("reset_main_outputs", {obs_m()[62:0], m_ovf}, 64'd0);
    chk("reset_bp_outputs", 64'({b_det, b_org, b_tc, b_tv, b_cid, b_comp, b_idx, b_last,
                                 b_rdone, b_cc, b_ovf}), 64'd0);
    dl_reset = 1'b1;
    q_m.delete();
    q_b.delete();
  endtask

  task automatic chk_queue(input string name, input logic [18:0] exp[$], input logic [18:0] got[$]);
    logic [18:0] a;
    chk({name, "_count"}, 64'(got.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++) begin
      a = (i < got.size()) ? got[i] : '1;
      chk($sformatf("%s_rec%0d", name, i), 64'(a), 64'(exp[i]));
    end
  endtask

  initial begin
    logic [18:0] exp_q[$];
    ready_m   = 1'b1;
    ready_b   = 1'b1;
    dl_reset  = 1'b0;
    dl_in_vec = 3'b000;

    //        in      det org     tc tv cid comp idx last rdone cc
    tbl[0]  = '{3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{3'b010, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{3'b010, 1, 3'b010, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{3'b100, 1, 3'b000, 0, 1, 1, 1, 1, 0, 0, 0};
    tbl[7]  = '{3'b010, 1, 3'b000, 1, 1, 1, 2, 2, 0, 0, 0};
    tbl[8]  = '{3'b000, 1, 3'b000, 0, 1, 1, 3, 1, 1, 0, 1};
    tbl[9]  = '{3'b000, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{3'b111, 1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1};

    // Fake stall: short blocked pulse never confirms.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      dl_in_vec = (i < 2) ? 3'b010 : 3'b000;
      #1;
      chk($sformatf("stall_det%0d", i), 64'({m_det, m_tv}), 64'd0);
      tick();
    end
    chk("stall_no_records", 64'(q_m.size()), 64'd0);

    // Filter break: one process releases before the filter expires.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      dl_in_vec = (i < 3) ? 3'b011 : 3'b001;
      #1;
      chk($sformatf("break_det%0d", i), 64'({m_det, m_tv}), 64'd0);
      tick();
    end

    // Single cycle, cycle-by-cycle; backpressured instance sees the same input.
    do_reset();
    ready_b = 1'b0;
    for (int i = 0; i < 11; i++) begin
      dl_in_vec = tbl[i].in;
      #1;
      chk($sformatf("single_vec%0d", i), obs_m(), pack_exp(tbl[i]));
      tick();
    end
    chk("single_no_overflow", 64'(m_ovf), 64'd0);

    // Backpressure: depth 2 holds the first two records, third is dropped.
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_hold%0d", i), 64'({b_tv, b_cid, b_comp, b_idx, b_last, b_ovf}),
          64'({1'b1, 8'd1, 8'd1, 2'd1, 1'b0, 1'b1}));
      tick();
    end
    ready_b = 1'b1;
    repeat (4) tick();
    exp_q = '{{8'd1, 8'd1, 2'd1, 1'b0}, {8'd1, 8'd2, 2'd2, 1'b0}};
    chk_queue("bp_drain", exp_q, q_b);
    chk("bp_empty", 64'(b_tv), 64'd0);

    // Two cycles sharing one deadlocked set.
    do_reset();
    drive(3'b011, 5);
    dl_in_vec = 3'b000;
    #1;
    chk("two_origin1", 64'({m_det, m_org}), 64'({1'b1, 3'b001}));
    tick();
    drive(3'b100, 1);
    drive(3'b001, 1);
    dl_in_vec = 3'b000;
    #1;
    chk("two_origin2", 64'({m_det, m_org}), 64'({1'b1, 3'b010}));
    tick();
    drive(3'b100, 1);
    drive(3'b010, 1);
    drive(3'b000, 3);
    chk("two_done", 64'({m_rdone, m_det, m_cc}), 64'({1'b1, 1'b1, 8'd2}));
    exp_q = '{{8'd1, 8'd1, 2'd0, 1'b0}, {8'd1, 8'd2, 2'd2, 1'b0}, {8'd1, 8'd3, 2'd0, 1'b1},
              {8'd2, 8'd1, 2'd1, 1'b0}, {8'd2, 8'd2, 2'd2, 1'b0}, {8'd2, 8'd3, 2'd1, 1'b1}};
    chk_queue("two", exp_q, q_m);

    // Reset in the middle of a report.
    do_reset();
    drive(3'b010, 5);
    drive(3'b000, 1);
    dl_in_vec = 3'b010;
    #1;
    chk("mid_pre", 64'({m_det, m_tc, m_tv}), 64'({1'b1, 1'b1, 1'b1}));
    dl_reset = 1'b0;
    #1;
    chk("mid_in_reset", 64'({m_det, m_tc, m_tv, m_org, m_rdone, m_cc}), 64'd0);
    tick();
    dl_reset  = 1'b1;
    dl_in_vec = 3'b000;
    #1;
    chk("mid_after", 64'({m_det, m_tv, m_cc}), 64'd0);
    tick();
    q_m.delete();
    drive(3'b001, 5);
    drive(3'b000, 1);
    drive(3'b001, 1);
    drive(3'b000, 3);
    exp_q = '{{8'd1, 8'd1, 2'd0, 1'b0}, {8'd1, 8'd2, 2'd0, 1'b1}};
    chk_queue("mid_restart", exp_q, q_m);
    chk("mid_restart_done", 64'({m_rdone, m_cc}), 64'({1'b1, 8'd1}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
